// File: rtl/seri_feed_pkg.sv
// seri_pkg: shared defaults and FSM state type for the seri_feed serial-accumulate feeder.
package seri_pkg;
    localparam int DATA_W_DEF    = 32;
    localparam int GROUP_LEN_DEF = 10;
    localparam int DEPTH_DEF     = 16;
    localparam int TIMEOUT_DEF   = 64;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_RES} feed_state_t;
endpackage

// File: rtl/seri_feed_fifo.sv
// seri_feed_fifo: synchronous FIFO with combinational read port and occupancy count.
module seri_feed_fifo
    import seri_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // Storage is not reset: contents are meaningless once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end
    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
endmodule

// File: rtl/seri_feed.sv
// seri_feed: buffers producer words and feeds gap-free groups to a serial accumulator, forwarding its result.
// Optional WAIT_RES watchdog enabled by defining SERI_FEED_TIMEOUT_EN.
module seri_feed
    import seri_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int GROUP_LEN = GROUP_LEN_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] acc_data,
    output logic              acc_en,
    input  logic [DATA_W-1:0] acc_result,
    input  logic              acc_res_valid,
    output logic [DATA_W-1:0] out_result,
    output logic              out_valid,
    output logic              out_err,
    output logic              busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(GROUP_LEN) + 1;
    if (DEPTH < GROUP_LEN || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("seri_feed: invalid DEPTH/GROUP_LEN/TIMEOUT");
    end
    feed_state_t       state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              ready_q;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty, push, pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic [DATA_W-1:0] acc_data_q, out_result_q, out_result_d;
    logic              acc_en_q, out_valid_q, out_valid_d;
`ifdef SERI_FEED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0]     timer_q, timer_d;
    logic              out_err_q, out_err_d;
`endif
    // ready_q holds in_ready low through reset and the release edge.
    assign in_ready = ready_q & ~fifo_full;
    assign push     = in_valid & in_ready;
    seri_feed_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        pop          = 1'b0;
        out_result_d = '0;
        out_valid_d  = 1'b0;
`ifdef SERI_FEED_TIMEOUT_EN
        timer_d      = '0;
        out_err_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (fifo_count >= CW'(GROUP_LEN)) state_d = SEND;
            end
            SEND: begin
                pop    = ~fifo_empty;
                beat_d = beat_q + BW'(1);
                if (beat_q == BW'(GROUP_LEN - 1)) begin
                    state_d = WAIT_RES;
                    beat_d  = '0;
                end
            end
            WAIT_RES: begin
                if (acc_res_valid) begin
                    out_result_d = acc_result;
                    out_valid_d  = 1'b1;
                    state_d      = IDLE;
                end
`ifdef SERI_FEED_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT - 1)) begin
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                    state_d     = IDLE;
                end else timer_d = timer_q + TW'(1);
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            ready_q      <= 1'b0;
            acc_data_q   <= '0;
            acc_en_q     <= 1'b0;
            out_result_q <= '0;
            out_valid_q  <= 1'b0;
`ifdef SERI_FEED_TIMEOUT_EN
            timer_q      <= '0;
            out_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            ready_q      <= 1'b1;
            acc_data_q   <= pop ? fifo_rdata : '0;
            acc_en_q     <= pop;
            out_result_q <= out_result_d;
            out_valid_q  <= out_valid_d;
`ifdef SERI_FEED_TIMEOUT_EN
            timer_q      <= timer_d;
            out_err_q    <= out_err_d;
`endif
        end
    end
    assign acc_data   = acc_data_q;
    assign acc_en     = acc_en_q;
    assign out_result = out_result_q;
    assign out_valid  = out_valid_q;
    assign busy       = state_q != IDLE;
`ifdef SERI_FEED_TIMEOUT_EN
    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_seri_feed.sv
// tb_seri_feed: directed self-checking bench for seri_feed (default parameters).
module tb_seri_feed;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, acc_res_valid = 1'b0;
    logic [31:0] in_data = '0, acc_result = '0;
    logic        in_ready, acc_en, out_valid, out_err, busy;
    logic [31:0] acc_data, out_result;
    int          total = 0, bad = 0, cyc = 0, ov_n = 0;
    logic [31:0] beats[$];
    int          beat_cyc[$], ov_cyc[$];
    logic [31:0] last_res = '0;
    logic        last_err = 1'b0;

    seri_feed dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .acc_data(acc_data), .acc_en(acc_en), .acc_result(acc_result), .acc_res_valid(acc_res_valid),
        .out_result(out_result), .out_valid(out_valid), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (acc_en) begin
            beats.push_back(acc_data);
            beat_cyc.push_back(cyc);
        end
        if (out_valid) begin
            ov_n++;
            ov_cyc.push_back(cyc);
            last_res = out_result;
            last_err = out_err;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beats.delete();
        beat_cyc.delete();
        ov_cyc.delete();
    endtask

    task automatic push_word(input logic [31:0] v);
        int  n = 0;
        logic took;
        in_data  = v;
        in_valid = 1'b1;
        do begin
            took = in_ready;
            step();
            n++;
        end while (!took && n < 200);
        in_valid = 1'b0;
        if (!took) chk("push_taken", took, 1);
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beats.size() < n && k < 300) begin
            step();
            k++;
        end
        if (beats.size() < n) chk("beat_wait", beats.size(), n);
    endtask

    task automatic pulse_res(input logic [31:0] v);
        acc_result    = v;
        acc_res_valid = 1'b1;
        step();
        acc_res_valid = 1'b0;
        acc_result    = '0;
    endtask

    task automatic chk_group(input string tag, input int first, input logic [31:0] base);
        int errs = 0;
        for (int i = 0; i < 10; i++)
            if (beats[first+i] !== base + 32'(i)) errs++;
        chk({tag, "_data"}, errs, 0);
        chk({tag, "_gapless"}, beat_cyc[first+9] - beat_cyc[first], 9);
    endtask

    initial begin
        int n0, k, errs;
        logic [31:0] e;
        // reset state
        repeat (3) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_acc_en", acc_en, 0);
        chk("rst_acc_data", acc_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        chk("release_ready_low", in_ready, 0);
        step();
        chk("release_ready_high", in_ready, 1);

        // 1: one group 1..10, result 55
        clear_mon();
        for (int i = 1; i <= 10; i++) push_word(32'(i));
        wait_beats(10);
        chk_group("t1", 0, 1);
        chk("t1_busy_wait", busy, 1);
        pulse_res(55);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_result", out_result, 55);
        chk("t1_out_err", out_err, 0);
        step();
        chk("t1_out_valid_pulse", out_valid, 0);
        chk("t1_idle", busy, 0);

        // 2: nine words do not start a group; the tenth does
        clear_mon();
        for (int i = 11; i <= 19; i++) push_word(32'(i));
        repeat (5) step();
        chk("t2_no_send", beats.size(), 0);
        chk("t2_idle", busy, 0);
        push_word(20);
        step();
        chk("t2_send_start", busy, 1);
        wait_beats(10);
        chk_group("t2", 0, 11);
        pulse_res(7);
        chk("t2_out_result", out_result, 7);
        step();

        // 3: fill FIFO while stuck in WAIT_RES; 17th word refused
        clear_mon();
        for (int i = 0; i < 10; i++) push_word(100 + 32'(i));
        wait_beats(10);
        for (int i = 0; i < 16; i++) push_word(200 + 32'(i));
        chk("t3_full_ready", in_ready, 0);
        in_data  = 216;
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        chk("t3_still_waiting", busy, 1);
        pulse_res(3);
        wait_beats(20);
        chk("t3_ready_after_send", in_ready, 1);
        chk_group("t3g2", 10, 200);
        pulse_res(4);
        step();
        for (int i = 0; i < 4; i++) push_word(220 + 32'(i));
        wait_beats(30);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            e = (i < 6) ? 210 + 32'(i) : 214 + 32'(i);
            if (beats[20+i] !== e) errs++;
        end
        chk("t3_17th_dropped", errs, 0);
        pulse_res(5);
        step();

        // 4: 30 words streamed, results returned ~3 cycles after each group
        clear_mon();
        fork
            begin
                for (int i = 0; i < 30; i++) push_word(300 + 32'(i));
            end
            begin
                for (int g = 0; g < 3; g++) begin
                    wait_beats(10 * (g + 1));
                    repeat (2) step();
                    pulse_res(32'(g + 1));
                end
            end
        join
        step();
        chk("t4_results", ov_cyc.size(), 3);
        chk_group("t4g0", 0, 300);
        chk_group("t4g1", 10, 310);
        chk_group("t4g2", 20, 320);
        for (int g = 0; g < 2; g++)
            chk("t4_no_overlap", beat_cyc[10*g+10] > ov_cyc[g] && ov_cyc[g] > beat_cyc[10*g+9], 1);
        chk("t4_last_result", last_res, 3);

        // 5: reset in the middle of a group
        clear_mon();
        for (int i = 0; i < 10; i++) push_word(400 + 32'(i));
        wait_beats(5);
        rst_n = 1'b0;
        step();
        chk("t5_acc_en_drop", acc_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_ready_in_rst", in_ready, 0);
        rst_n = 1'b1;
        step();
        chk("t5_ready_back", in_ready, 1);
        clear_mon();
        for (int i = 0; i < 9; i++) push_word(500 + 32'(i));
        repeat (4) step();
        chk("t5_count_cleared", beats.size(), 0);
        push_word(509);
        wait_beats(10);
        chk_group("t5", 0, 500);
        pulse_res(9);
        chk("t5_out_result", out_result, 9);
        step();

        // stray result while idle is ignored
        n0 = ov_n;
        pulse_res(99);
        chk("stray_out_valid", out_valid, 0);
        step();
        chk("stray_count", ov_n, n0);
        chk("stray_idle", busy, 0);

`ifdef SERI_FEED_TIMEOUT_EN
        // 6: watchdog expiry
        clear_mon();
        for (int i = 0; i < 10; i++) push_word(600 + 32'(i));
        wait_beats(10);
        k = 0;
        while (ov_cyc.size() == 0 && k < 200) begin
            step();
            k++;
        end
        chk("t6_timeout_seen", ov_cyc.size(), 1);
        chk("t6_timeout_cycles", ov_cyc[0] - beat_cyc[9], 64);
        chk("t6_err", last_err, 1);
        chk("t6_result", last_res, 0);
        step();
        chk("t6_idle", busy, 0);
        n0 = ov_n;
        pulse_res(77);
        step();
        chk("t6_stray", ov_n, n0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
